// File: rtl/dev_sram_pkg.sv
// Shared types and constants for the dev-chassis SRAM controller.
// FSM states, requester identities and SRAM geometry live here.
package dev_sram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic {
    GRANT_DUT = 1'b0,
    GRANT_DBG = 1'b1
  } grant_e;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;

  // Requesters see a 64K-word space; the two top SRAM address bits are tied low.
  function automatic logic [SRAM_AW-1:0] word_to_sram_addr(input logic [15:0] word_addr);
    return {2'b00, word_addr};
  endfunction

endpackage

// File: rtl/dev_sram_if.sv
// Request-side bundle for the SRAM controller: DUT port and debug/loader port.
// master = requester side (testbench / chassis), slave = controller side.
interface dev_sram_if;
  import dev_sram_pkg::*;

  logic               i_dutReq;
  logic               i_dutWr;
  logic [15:0]        i_dutAddr;
  logic [SRAM_DW-1:0] i_dutWrData;
  logic [SRAM_DW-1:0] o_dutRdData;
  logic               o_dutAck;

  logic               i_dbgReq;
  logic               i_dbgWr;
  logic [15:0]        i_dbgAddr;
  logic [SRAM_DW-1:0] i_dbgWrData;
  logic [SRAM_DW-1:0] o_dbgRdData;
  logic               o_dbgAck;

  modport master (
    output i_dutReq, i_dutWr, i_dutAddr, i_dutWrData,
    input  o_dutRdData, o_dutAck,
    output i_dbgReq, i_dbgWr, i_dbgAddr, i_dbgWrData,
    input  o_dbgRdData, o_dbgAck
  );

  modport slave (
    input  i_dutReq, i_dutWr, i_dutAddr, i_dutWrData,
    output o_dutRdData, o_dutAck,
    input  i_dbgReq, i_dbgWr, i_dbgAddr, i_dbgWrData,
    output o_dbgRdData, o_dbgAck
  );

endinterface

// File: rtl/dev_sram_arb.sv
// Two-requester round-robin arbiter. On a tie the port not granted last wins;
// the history register starts at "debug" so the DUT wins the first tie.
module dev_sram_arb
  import dev_sram_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   req_dut_i,
  input  logic   req_dbg_i,
  input  logic   update_i,
  input  grant_e winner_i,
  output grant_e grant_o
);

  grant_e last_q, last_d;

  // Last-grant history register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= GRANT_DBG;
    end else begin
      last_q <= last_d;
    end
  end

  // History update and grant selection.
  always_comb begin
    last_d  = last_q;
    grant_o = GRANT_DUT;
    if (update_i) begin
      last_d = winner_i;
    end else begin
      last_d = last_q;
    end
    case ({req_dut_i, req_dbg_i})
      2'b10:   grant_o = GRANT_DUT;
      2'b01:   grant_o = GRANT_DBG;
      2'b11:   grant_o = (last_q == GRANT_DBG) ? GRANT_DUT : GRANT_DBG;
      default: grant_o = GRANT_DUT;
    endcase
  end

endmodule

// File: rtl/dev_sram_ctrl.sv
// Sequences the DE2 asynchronous 16-bit SRAM for the DUT and debug ports:
// IDLE -> SETUP -> ACTIVE (ACCESS_CYCLES) -> DONE, all pins from flops.
module dev_sram_ctrl
  import dev_sram_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  dev_sram_if.slave          bus,
  output logic [SRAM_AW-1:0] o_sramAddr,
  inout  wire  [SRAM_DW-1:0] io_sramDq,
  output logic               o_sramCeN,
  output logic               o_sramOeN,
  output logic               o_sramWeN,
  output logic               o_sramUbN,
  output logic               o_sramLbN,
  output logic               o_busy
);

  localparam int            CW       = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  grant_e             gnt_q, gnt_d;
  logic               wr_q, wr_d;
  logic [15:0]        addr_q, addr_d;
  logic [SRAM_DW-1:0] wdata_q, wdata_d;
  logic [SRAM_DW-1:0] dut_rd_q, dut_rd_d;
  logic [SRAM_DW-1:0] dbg_rd_q, dbg_rd_d;
  logic               dut_ack_q, dut_ack_d;
  logic               dbg_ack_q, dbg_ack_d;
  logic               ce_n_q, ce_n_d;
  logic               oe_n_q, oe_n_d;
  logic               we_n_q, we_n_d;
  logic               dq_oe_q, dq_oe_d;
  logic               busy_q, busy_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;

  grant_e arb_grant;
  logic   arb_update;

  dev_sram_arb u_arb (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .req_dut_i (bus.i_dutReq),
    .req_dbg_i (bus.i_dbgReq),
    .update_i  (arb_update),
    .winner_i  (gnt_q),
    .grant_o   (arb_grant)
  );

  // State register, access latches and registered pin/port outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gnt_q       <= GRANT_DUT;
      wr_q        <= 1'b0;
      addr_q      <= 16'h0000;
      wdata_q     <= '0;
      dut_rd_q    <= '0;
      dbg_rd_q    <= '0;
      dut_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      busy_q      <= 1'b0;
      sram_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      dut_rd_q    <= dut_rd_d;
      dbg_rd_q    <= dbg_rd_d;
      dut_ack_q   <= dut_ack_d;
      dbg_ack_q   <= dbg_ack_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      dq_oe_q     <= dq_oe_d;
      busy_q      <= busy_d;
      sram_addr_q <= sram_addr_d;
    end
  end

  // Next state, datapath, and pin values decoded from the *next* state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    dut_rd_d   = dut_rd_q;
    dbg_rd_d   = dbg_rd_q;
    arb_update = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_dutReq || bus.i_dbgReq) begin
          gnt_d   = arb_grant;
          state_d = SETUP;
          if (arb_grant == GRANT_DUT) begin
            wr_d    = bus.i_dutWr;
            addr_d  = bus.i_dutAddr;
            wdata_d = bus.i_dutWrData;
          end else begin
            wr_d    = bus.i_dbgWr;
            addr_d  = bus.i_dbgAddr;
            wdata_d = bus.i_dbgWrData;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACTIVE;
      end
      ACTIVE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          // Capture on the last strobe cycle, while OE_N is still low.
          if (!wr_q && (gnt_q == GRANT_DUT)) begin
            dut_rd_d = io_sramDq;
          end else if (!wr_q) begin
            dbg_rd_d = io_sramDq;
          end else begin
            dut_rd_d = dut_rd_q;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        arb_update = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ce_n_d      = (state_d == IDLE);
    oe_n_d      = !((state_d == ACTIVE) && !wr_d);
    we_n_d      = !((state_d == ACTIVE) && wr_d);
    dq_oe_d     = (state_d != IDLE) && wr_d;
    busy_d      = (state_d != IDLE);
    dut_ack_d   = (state_d == DONE) && (gnt_d == GRANT_DUT);
    dbg_ack_d   = (state_d == DONE) && (gnt_d == GRANT_DBG);
    sram_addr_d = (state_d == SETUP) ? word_to_sram_addr(addr_d) : sram_addr_q;
  end

  assign io_sramDq       = dq_oe_q ? wdata_q : {SRAM_DW{1'bz}};
  assign o_sramAddr      = sram_addr_q;
  assign o_sramCeN       = ce_n_q;
  assign o_sramUbN       = ce_n_q;
  assign o_sramLbN       = ce_n_q;
  assign o_sramOeN       = oe_n_q;
  assign o_sramWeN       = we_n_q;
  assign o_busy          = busy_q;
  assign bus.o_dutAck    = dut_ack_q;
  assign bus.o_dbgAck    = dbg_ack_q;
  assign bus.o_dutRdData = dut_rd_q;
  assign bus.o_dbgRdData = dbg_rd_q;

endmodule

// File: tb/tb_dev_sram_ctrl.sv
// Self-checking bench for dev_sram_ctrl: behavioural SRAM, ordered ack scoreboard,
// vector table for single accesses, hand-written reset/tie/contention/N=1/N=15 sequences.
module tb_dev_sram_ctrl;
  import dev_sram_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- main instance, ACCESS_CYCLES default (2) ----------------
  dev_sram_if m_if();
  logic [17:0] m_addr;
  wire  [15:0] m_dq;
  logic m_ce, m_oe, m_we, m_ub, m_lb, m_busy;
  logic [15:0] mem [0:65535];

  assign m_dq = (!m_ce && !m_oe) ? mem[m_addr[15:0]] : 16'hzzzz;
  always @(posedge clk) begin
    if (!m_ce && !m_we) mem[m_addr[15:0]] <= m_dq;
  end

  dev_sram_ctrl u_main (
    .i_clk(clk), .i_rst(rst), .bus(m_if),
    .o_sramAddr(m_addr), .io_sramDq(m_dq),
    .o_sramCeN(m_ce), .o_sramOeN(m_oe), .o_sramWeN(m_we),
    .o_sramUbN(m_ub), .o_sramLbN(m_lb), .o_busy(m_busy)
  );

  // ---------------- N=1 and N=15 instances (read-only pattern SRAMs) ----------------
  dev_sram_if n1_if();
  dev_sram_if n15_if();
  logic [17:0] n1_addr, n15_addr;
  wire  [15:0] n1_dq, n15_dq;
  logic n1_ce, n1_oe, n1_we, n1_ub, n1_lb, n1_busy;
  logic n15_ce, n15_oe, n15_we, n15_ub, n15_lb, n15_busy;

  assign n1_dq  = (!n1_ce && !n1_oe)   ? 16'hC3C3 : 16'hzzzz;
  assign n15_dq = (!n15_ce && !n15_oe) ? 16'h3C5A : 16'hzzzz;

  dev_sram_ctrl #(.ACCESS_CYCLES(1)) u_n1 (
    .i_clk(clk), .i_rst(rst), .bus(n1_if),
    .o_sramAddr(n1_addr), .io_sramDq(n1_dq),
    .o_sramCeN(n1_ce), .o_sramOeN(n1_oe), .o_sramWeN(n1_we),
    .o_sramUbN(n1_ub), .o_sramLbN(n1_lb), .o_busy(n1_busy)
  );

  dev_sram_ctrl #(.ACCESS_CYCLES(15)) u_n15 (
    .i_clk(clk), .i_rst(rst), .bus(n15_if),
    .o_sramAddr(n15_addr), .io_sramDq(n15_dq),
    .o_sramCeN(n15_ce), .o_sramOeN(n15_oe), .o_sramWeN(n15_we),
    .o_sramUbN(n15_ub), .o_sramLbN(n15_lb), .o_busy(n15_busy)
  );

  bit          sel15 = 1'b0;
  logic        s_ack, s_oe;
  logic [17:0] s_addr;
  logic [15:0] s_rd;
  always_comb begin
    if (sel15) begin
      s_ack = n15_if.o_dutAck; s_oe = n15_oe; s_addr = n15_addr; s_rd = n15_if.o_dutRdData;
    end else begin
      s_ack = n1_if.o_dutAck;  s_oe = n1_oe;  s_addr = n1_addr;  s_rd = n1_if.o_dutRdData;
    end
  end

  // ---------------- scoreboard: expected accesses in grant order ----------------
  typedef struct {
    bit          dbg;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] rd;
  } exp_t;
  exp_t sb[$];

  int oe_low = 0;
  int we_low = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      oe_low = 0;
      we_low = 0;
    end else begin
      if (!m_oe) oe_low++;
      if (!m_we) we_low++;
      if (m_if.o_dutAck || m_if.o_dbgAck) begin
        check("single_ack", {m_if.o_dutAck, m_if.o_dbgAck} == 2'b11, 1'b0);
        check("ack_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("ack_port", m_if.o_dbgAck, e.dbg);
          check("ack_addr", m_addr, {2'b00, e.addr});
          check("we_width", we_low, e.wr ? 2 : 0);
          check("oe_width", oe_low, e.wr ? 0 : 2);
          if (!e.wr) check("rd_data", e.dbg ? m_if.o_dbgRdData : m_if.o_dutRdData, e.rd);
        end
        oe_low = 0;
        we_low = 0;
      end
    end
  end

  task automatic drive(input bit dbg, input bit req, input bit wr, input logic [15:0] a, input logic [15:0] d);
    if (dbg) begin
      m_if.i_dbgReq = req; m_if.i_dbgWr = wr; m_if.i_dbgAddr = a; m_if.i_dbgWrData = d;
    end else begin
      m_if.i_dutReq = req; m_if.i_dutWr = wr; m_if.i_dutAddr = a; m_if.i_dutWrData = d;
    end
  endtask

  // One access from an idle bus; lat = cycles from request to ack (-1 on timeout).
  task automatic single_access(input bit dbg, input bit wr, input logic [15:0] a, input logic [15:0] d, output int lat);
    @(posedge clk); #1;
    drive(dbg, 1'b1, wr, a, d);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (dbg ? m_if.o_dbgAck : m_if.o_dutAck) begin
        lat = c;
        break;
      end
    end
    drive(dbg, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  // Both ports hold req while they have work queued in plist.
  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
  } req_t;
  req_t plist [2][4];
  int   pn [2];
  int   ack_cyc [2][4];

  task automatic run_pair();
    int idx [2];
    int cyc;
    idx[0] = 0; idx[1] = 0;
    @(posedge clk); #1;
    for (int p = 0; p < 2; p++)
      if (pn[p] > 0) drive(bit'(p), 1'b1, plist[p][0].wr, plist[p][0].addr, plist[p][0].data);
    cyc = 0;
    while ((idx[0] < pn[0] || idx[1] < pn[1]) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      for (int p = 0; p < 2; p++) begin
        if ((p == 0 ? m_if.o_dutAck : m_if.o_dbgAck) && idx[p] < pn[p]) begin
          ack_cyc[p][idx[p]] = cyc;
          idx[p]++;
          if (idx[p] < pn[p])
            drive(bit'(p), 1'b1, plist[p][idx[p]].wr, plist[p][idx[p]].addr, plist[p][idx[p]].data);
          else
            drive(bit'(p), 1'b0, 1'b0, 16'h0000, 16'h0000);
        end
      end
    end
    check("pair_in_budget", cyc < 200, 1'b1);
  endtask

  // Read through the N=1 or N=15 instance, measuring latency and OE_N width.
  task automatic narrow_read(input bit big, input logic [15:0] a, output int lat, output int oe_n_low, output int hi_bad);
    sel15 = big;
    @(posedge clk); #1;
    if (big) begin n15_if.i_dutReq = 1'b1; n15_if.i_dutAddr = a; end
    else     begin n1_if.i_dutReq  = 1'b1; n1_if.i_dutAddr  = a; end
    lat = -1; oe_n_low = 0; hi_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (!s_oe) oe_n_low++;
      if (s_addr[17:16] != 2'b00) hi_bad++;
      if (s_ack) begin
        lat = c;
        break;
      end
    end
    n15_if.i_dutReq = 1'b0;
    n1_if.i_dutReq  = 1'b0;
  endtask

  typedef struct {
    bit          dbg;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] rd;
  } vec_t;
  vec_t        vecs [8];
  logic [15:0] last_rd [2];

  initial begin
    int lat, oe_cnt, hi_bad, acks, first_ack, second_ack;
    vecs[0] = '{1'b0, 1'b1, 16'h1234, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b1, 16'h0001, 16'hA5A5, 16'h0000};
    vecs[3] = '{1'b1, 1'b0, 16'h0001, 16'h0000, 16'hA5A5};
    vecs[4] = '{1'b0, 1'b1, 16'hFFFF, 16'h1357, 16'h0000};
    vecs[5] = '{1'b0, 1'b0, 16'h0001, 16'h0000, 16'hA5A5};
    vecs[6] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h1357};
    vecs[7] = '{1'b1, 1'b1, 16'h0000, 16'h0F0F, 16'h0000};
    last_rd[0] = 16'h0000; last_rd[1] = 16'h0000;

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    n1_if.i_dutReq = 1'b0;  n1_if.i_dutWr = 1'b0;  n1_if.i_dutAddr = 16'h0000;  n1_if.i_dutWrData = 16'h0000;
    n1_if.i_dbgReq = 1'b0;  n1_if.i_dbgWr = 1'b0;  n1_if.i_dbgAddr = 16'h0000;  n1_if.i_dbgWrData = 16'h0000;
    n15_if.i_dutReq = 1'b0; n15_if.i_dutWr = 1'b0; n15_if.i_dutAddr = 16'h0000; n15_if.i_dutWrData = 16'h0000;
    n15_if.i_dbgReq = 1'b0; n15_if.i_dbgWr = 1'b0; n15_if.i_dbgAddr = 16'h0000; n15_if.i_dbgWrData = 16'h0000;
    repeat (3) @(posedge clk);
    #1;

    check("rst_strobes", {m_ce, m_oe, m_we, m_ub, m_lb}, 5'b11111);
    check("rst_addr", m_addr, 18'h00000);
    check("rst_acks", {m_if.o_dutAck, m_if.o_dbgAck}, 2'b00);
    check("rst_rddata", {m_if.o_dutRdData, m_if.o_dbgRdData}, 32'h0000_0000);
    check("rst_busy", m_busy, 1'b0);
    check("rst_dq_oe", u_main.dq_oe_q, 1'b0);
    rst = 1'b0;

    // Table of isolated accesses.
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{vecs[i].dbg, vecs[i].wr, vecs[i].addr, vecs[i].rd});
      single_access(vecs[i].dbg, vecs[i].wr, vecs[i].addr, vecs[i].data, lat);
      check($sformatf("vec%0d_latency", i), lat, 4);
      if (vecs[i].wr)
        check($sformatf("vec%0d_rd_hold", i), vecs[i].dbg ? m_if.o_dbgRdData : m_if.o_dutRdData, last_rd[vecs[i].dbg]);
      else
        last_rd[vecs[i].dbg] = vecs[i].rd;
    end

    // Reset in the middle of a write: no ack may follow.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 16'h5555, 16'hDEAD);
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_we_low", m_we, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_strobes", {m_ce, m_oe, m_we, m_ub, m_lb}, 5'b11111);
    check("midrst_busy", m_busy, 1'b0);
    check("midrst_dq_oe", u_main.dq_oe_q, 1'b0);
    check("midrst_acks", {m_if.o_dutAck, m_if.o_dbgAck}, 2'b00);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Tie right after reset: DUT first, debug five cycles later.
    pn[0] = 1; pn[1] = 1;
    plist[0][0] = '{1'b0, 16'h1234, 16'h0000};
    plist[1][0] = '{1'b0, 16'h0001, 16'h0000};
    sb.push_back('{1'b0, 1'b0, 16'h1234, 16'hBEEF});
    sb.push_back('{1'b1, 1'b0, 16'h0001, 16'hA5A5});
    run_pair();
    check("tie_dut_ack_cyc", ack_cyc[0][0], 4);
    check("tie_dbg_ack_cyc", ack_cyc[1][0], 9);

    // Sustained contention, four accesses alternating.
    pn[0] = 2; pn[1] = 2;
    plist[0][0] = '{1'b1, 16'h2000, 16'h1111};
    plist[0][1] = '{1'b0, 16'h2000, 16'h0000};
    plist[1][0] = '{1'b1, 16'h3000, 16'h2222};
    plist[1][1] = '{1'b0, 16'h3000, 16'h0000};
    sb.push_back('{1'b0, 1'b1, 16'h2000, 16'h0000});
    sb.push_back('{1'b1, 1'b1, 16'h3000, 16'h0000});
    sb.push_back('{1'b0, 1'b0, 16'h2000, 16'h1111});
    sb.push_back('{1'b1, 1'b0, 16'h3000, 16'h2222});
    run_pair();
    check("cont_dut_ack1", ack_cyc[0][0], 4);
    check("cont_dbg_ack1", ack_cyc[1][0], 9);
    check("cont_dut_ack2", ack_cyc[0][1], 14);
    check("cont_dbg_ack2", ack_cyc[1][1], 19);

    // Held request: req stays high through the IDLE after ack -> one extra access.
    sb.push_back('{1'b0, 1'b1, 16'h4000, 16'h0000});
    sb.push_back('{1'b0, 1'b1, 16'h4000, 16'h0000});
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 16'h4000, 16'h7777);
    first_ack = -1; second_ack = -1; acks = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (m_if.o_dutAck) begin
        acks++;
        if (first_ack < 0) first_ack = c; else second_ack = c;
      end
      if (c == first_ack + 2 && first_ack > 0) drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    end
    check("held_ack_count", acks, 2);
    check("held_first_ack", first_ack, 4);
    check("held_second_ack", second_ack, 9);

    // Parameter corners.
    narrow_read(1'b0, 16'hABCD, lat, oe_cnt, hi_bad);
    check("n1_latency", lat, 3);
    check("n1_oe_width", oe_cnt, 1);
    check("n1_addr_hi", hi_bad, 0);
    check("n1_addr", s_addr, 18'h0ABCD);
    check("n1_rd", s_rd, 16'hC3C3);
    narrow_read(1'b1, 16'hFFFF, lat, oe_cnt, hi_bad);
    check("n15_latency", lat, 17);
    check("n15_oe_width", oe_cnt, 15);
    check("n15_addr_hi", hi_bad, 0);
    check("n15_addr", s_addr, 18'h0FFFF);
    check("n15_rd", s_rd, 16'h3C5A);

    repeat (5) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dev_sram_ctrl.md
# dev_sram_ctrl

- Sequences the DE2 board's asynchronous 16-bit SRAM on behalf of two requesters: the DUT memory port and a chassis debug/loader port.
- Arbitrates between them round-robin and generates CE_N/OE_N/WE_N/UB_N/LB_N timing with a fixed, parameterised strobe width.
- Owns the tri-state control of SRAM_DQ.
- Sits in the dev chassis top level, between the DUT instance, the future debug port and the SRAM pins. It replaces the static "disconnect" ties on those pins.

## Interface

Parameters:
- ACCESS_CYCLES, default 2: number of cycles OE_N or WE_N is held low per access. Legal range 1..15.

Ports:
- i_clk  in  1  chassis clock (PLL output); the only clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_dutReq  in  1  DUT access request; held until o_dutAck.
- i_dutWr  in  1  1 = write, 0 = read; valid while i_dutReq is high.
- i_dutAddr  in  16  DUT word address.
- i_dutWrData  in  16  DUT write data.
- o_dutRdData  out  16  last DUT read result.
- o_dutAck  out  1  one-cycle completion pulse to the DUT.
- i_dbgReq, i_dbgWr, i_dbgAddr[15:0], i_dbgWrData[15:0], o_dbgRdData[15:0], o_dbgAck: same semantics, debug port.
- o_sramAddr  out  18  SRAM address; bits [17:16] always 0.
- io_sramDq  inout  16  SRAM data; driven only during writes, Z otherwise.
- o_sramCeN, o_sramOeN, o_sramWeN, o_sramUbN, o_sramLbN  out  1 each  active-low SRAM controls.
- o_busy  out  1  high in any state other than IDLE.

## Operation

States are IDLE, SETUP, ACTIVE, DONE.

- **IDLE**
  - All strobes high; DQ released.
  - If any request is high, grant one requester and latch its address, write flag and write data; next state SETUP.
- **Arbitration**
  - A single request wins unconditionally.
  - If both requests are high, the port not granted last wins.
  - The last-grant register resets to "debug", so the DUT wins the first tie.
- **SETUP** (1 cycle)
  - CE_N, UB_N and LB_N go low; address is driven.
  - OE_N and WE_N stay high.
  - On a write, DQ is driven with the latched data.
  - Next state ACTIVE with the counter loaded to 0.
- **ACTIVE** (ACCESS_CYCLES cycles)
  - Read: OE_N low.
  - Write: WE_N low and DQ driven.
  - The counter increments each cycle. When count == ACCESS_CYCLES-1:
    - on a read, io_sramDq is captured into the granted port's RdData register;
    - next state is DONE.
- **DONE** (1 cycle)
  - OE_N and WE_N return high.
  - CE_N, UB_N, LB_N and the address are still held.
  - DQ is still driven on a write, as data hold past WE_N rise.
  - The granted port's ack pulses high; the last-grant register is updated.
  - Next state IDLE.
- **Request sampling**
  - Requests are sampled only in IDLE.
  - A requester must drop req in the cycle after ack. If req is still high in IDLE, it is taken as a new request.
- **Read data registers**
  - Each port's RdData holds its value until that port's next read completes.
  - Writes do not change RdData.
- **Counter width**: $clog2(ACCESS_CYCLES+1) bits, no wrap inside an access.
- **Reset**
  - Effective at the next edge, including mid-access.
  - State → IDLE, with no ack issued for the aborted access.
  - Reset values:
    - o_sramCeN, o_sramOeN, o_sramWeN, o_sramUbN, o_sramLbN = 1;
    - o_sramAddr = 0;
    - DQ = Z;
    - both acks = 0;
    - both RdData = 0;
    - o_busy = 0;
    - last-grant = debug.

## Timing

Let N = ACCESS_CYCLES, with the request high in cycle 0.

- SETUP occupies cycle 1.
- ACTIVE occupies cycles 2..1+N.
- DONE and ack occur in cycle 2+N.
- IDLE occurs in cycle 3+N, the earliest next grant.
- Throughput: one access per 3+N cycles.
- For N=2: ack is in cycle 4 and the period is 5 cycles.
- Read data is valid on RdData in the ack cycle.
- All outputs are registered; there are no combinational paths from requests to the SRAM pins.
- The DQ output-enable is a registered flop, asserted in SETUP through DONE only when the latched write flag is set.

## Structure

- Package dev_sram_pkg holds:
  - the state enum (IDLE, SETUP, ACTIVE, DONE);
  - the grant enum (GRANT_DUT, GRANT_DBG);
  - the SRAM address width constant (18) and data width constant (16).
- One sub-module, dev_sram_arb: a two-requester round-robin arbiter.
  - Inputs: requests, an update strobe and the winner.
  - Output: grant.
  - Internal: the last-grant register.
- The FSM, counter, latches and pin drivers stay in dev_sram_ctrl.

## Test plan

- **Reset**: assert i_rst mid-ACTIVE of a write.
  - Next cycle: all strobes 1, DQ = Z, o_busy = 0.
  - No ack ever follows for the aborted access.
- **DUT write then read, N=2**
  - Stimulus: write 0xBEEF to 0x1234, then read 0x1234.
  - o_sramAddr = 0x01234 and WE_N low for exactly 2 cycles.
  - Ack in cycle 4 after each request; o_dutRdData = 0xBEEF.
- **Tie after reset**: both requests high in cycle 0.
  - DUT is served first.
  - Debug is granted in the following IDLE, with its ack 5 cycles after the DUT ack.
- **Sustained contention**: both ports hold requests for 4 accesses.
  - Grant order is DUT, DBG, DUT, DBG.
  - Each port's RdData reflects only its own reads.
- **Held request**: DUT keeps req high one cycle past ack.
  - A second access starts.
  - After req drops at the ack, exactly one access occurs.
- **Parameter N=1 and N=15**
  - Ack arrives at cycle 3 and cycle 17 respectively.
  - OE_N is low for exactly N cycles.
  - Upper address bits are always 0.
